// File: rtl/inst_pkg.sv
// Shared RV32I field-level definitions: class codes, op indices, opcodes, NOP.
// Consumed by both the encoder and the decoder.
package inst_pkg;

  typedef enum logic [2:0] {
    CLS_R  = 3'd0,
    CLS_I  = 3'd1,
    CLS_L  = 3'd2,
    CLS_S  = 3'd3,
    CLS_B  = 3'd4,
    CLS_J  = 3'd5,
    CLS_JR = 3'd6,
    CLS_U  = 3'd7
  } cls_e;

  localparam logic [3:0] OP0 = 4'd0;
  localparam logic [3:0] OP1 = 4'd1;
  localparam logic [3:0] OP2 = 4'd2;
  localparam logic [3:0] OP3 = 4'd3;
  localparam logic [3:0] OP4 = 4'd4;
  localparam logic [3:0] OP5 = 4'd5;
  localparam logic [3:0] OP6 = 4'd6;
  localparam logic [3:0] OP7 = 4'd7;
  localparam logic [3:0] OP8 = 4'd8;
  localparam logic [3:0] OP9 = 4'd9;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_L     = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_J     = 7'b1101111;
  localparam logic [6:0] OPC_JR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0]  FUNC7_ALT = 7'h20;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  typedef struct packed {
    cls_e        cls;
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } fields_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // True when v is representable as a signed value of the given width.
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= bits && v[i] != v[bits-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational fields -> 32-bit RV32I word, with an illegal flag (NOP substituted).
// Optional immediate range checking under INST_ENCODE_IMM_CHECK_EN.
module inst_field_pack
  import inst_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] word,
  output logic        illegal
);

  logic [31:0] raw;
  logic        bad_op;
  logic        imm_ok;
  logic [2:0]  f3;
  logic        is_shift;

  assign f3       = f.op[2:0];
  assign is_shift = (f.op == OP1) || (f.op == OP5) || (f.op == OP9);

  always_comb begin
    raw    = '0;
    bad_op = 1'b0;
    case (f.cls)
      CLS_R: begin
        if (f.op <= OP7)
          raw = {7'b0, f.rs2, f.rs1, f3, f.rd, OPC_R};
        else if (f.op == OP8)
          raw = {FUNC7_ALT, f.rs2, f.rs1, 3'd0, f.rd, OPC_R};
        else if (f.op == OP9)
          raw = {FUNC7_ALT, f.rs2, f.rs1, 3'd5, f.rd, OPC_R};
        else
          bad_op = 1'b1;
      end
      CLS_I: begin
        if (f.op == OP1 || f.op == OP5)
          raw = {7'b0, f.imm[4:0], f.rs1, f3, f.rd, OPC_I};
        else if (f.op == OP9)
          raw = {FUNC7_ALT, f.imm[4:0], f.rs1, 3'd5, f.rd, OPC_I};
        else if (f.op <= OP7)
          raw = {f.imm[11:0], f.rs1, f3, f.rd, OPC_I};
        else
          bad_op = 1'b1;
      end
      CLS_L: begin
        if (f.op <= OP2 || f.op == OP4 || f.op == OP5)
          raw = {f.imm[11:0], f.rs1, f3, f.rd, OPC_L};
        else
          bad_op = 1'b1;
      end
      CLS_S: begin
        if (f.op <= OP2)
          raw = {f.imm[11:5], f.rs2, f.rs1, f3, f.imm[4:0], OPC_S};
        else
          bad_op = 1'b1;
      end
      CLS_B: begin
        if (f.op <= OP1 || (f.op >= OP4 && f.op <= OP7))
          raw = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f3, f.imm[4:1], f.imm[11], OPC_B};
        else
          bad_op = 1'b1;
      end
      CLS_J: begin
        if (f.op == OP0)
          raw = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, OPC_J};
        else
          bad_op = 1'b1;
      end
      CLS_JR: begin
        if (f.op == OP0)
          raw = {f.imm[11:0], f.rs1, 3'd0, f.rd, OPC_JR};
        else
          bad_op = 1'b1;
      end
      CLS_U: begin
        if (f.op == OP0)
          raw = {f.imm[31:12], f.rd, OPC_LUI};
        else if (f.op == OP1)
          raw = {f.imm[31:12], f.rd, OPC_AUIPC};
        else
          bad_op = 1'b1;
      end
    endcase
  end

`ifdef INST_ENCODE_IMM_CHECK_EN
  always_comb begin
    imm_ok = 1'b1;
    case (f.cls)
      CLS_I:          imm_ok = is_shift ? (f.imm[31:5] == '0) : fits_signed(f.imm, 12);
      CLS_L, CLS_S,
      CLS_JR:         imm_ok = fits_signed(f.imm, 12);
      CLS_B:          imm_ok = fits_signed(f.imm, 13) && !f.imm[0];
      CLS_J:          imm_ok = fits_signed(f.imm, 21) && !f.imm[0];
      CLS_U:          imm_ok = (f.imm[11:0] == '0);
      default:        imm_ok = 1'b1;
    endcase
  end
`else
  // Without the check, out-of-range immediates are simply truncated by the slices above.
  assign imm_ok = 1'b1 | is_shift;
`endif

  assign illegal = bad_op || !imm_ok;
  assign word    = illegal ? NOP_WORD : raw;

endmodule

// File: rtl/inst_encode.sv
// Streaming RV32I encoder / IMEM program loader: accept beat, register, encode, write.
// Build option: INST_ENCODE_IMM_CHECK_EN enables immediate range checking in inst_field_pack.
module inst_encode
  import inst_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cls,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            state_reg, state_next;
  fields_t           in_fields;
  fields_t           s1_fields_reg;
  logic              s1_valid_reg, s1_last_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              mem_we_reg, done_reg, err_reg, wrap_reg;
  logic [ADDR_W-1:0] mem_addr_reg, err_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic              accept;

  assign in_fields = {in_cls, in_op, in_rs1, in_rs2, in_rd, in_imm};
  assign in_ready  = (state_reg == ST_RUN);
  assign busy      = (state_reg != ST_IDLE);
  assign accept    = in_ready && in_valid;

  inst_field_pack u_pack (
    .f       (s1_fields_reg),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (in_valid && in_last) state_next = ST_DRAIN;
      // done_reg marks the cycle the last write is on the port
      ST_DRAIN: if (done_reg) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      s1_valid_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_fields_reg <= '0;
      addr_reg      <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_addr_reg  <= '0;
      wrap_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s1_valid_reg <= accept;
      if (accept) begin
        s1_fields_reg <= in_fields;
        s1_last_reg   <= in_last;
      end
      mem_we_reg <= s1_valid_reg;
      done_reg   <= s1_valid_reg && s1_last_reg;
      if (state_reg == ST_IDLE && start) begin
        addr_reg     <= BASE;
        err_reg      <= 1'b0;
        err_addr_reg <= '0;
        wrap_reg     <= 1'b0;
      end
      if (s1_valid_reg) begin
        mem_addr_reg  <= addr_reg;
        mem_wdata_reg <= pack_word;
        addr_reg      <= addr_reg + 1'b1;
        if (&addr_reg) wrap_reg <= 1'b1;
        if (pack_illegal) begin
          err_reg <= 1'b1;
          if (!err_reg) err_addr_reg <= addr_reg;
        end
      end
    end
  end

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign err_addr  = err_addr_reg;
  assign wrap      = wrap_reg;

endmodule

// File: tb/tb_inst_encode.sv
// Bench for inst_encode: two instances (ADDR_W 10 and 2) share one stimulus stream,
// checked every cycle against a field-rule model plus literal expectations.
module tb_inst_encode;
  import inst_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, in_valid, in_last;
  logic [2:0]  in_cls;
  logic [3:0]  in_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;

  logic        rdy0, we0, busy0, done0, err0, wrap0;
  logic [9:0]  addr0, eaddr0;
  logic [31:0] wdata0;
  logic        rdy1, we1, busy1, done1, err1, wrap1;
  logic [1:0]  addr1, eaddr1;
  logic [31:0] wdata1;

  inst_encode #(.ADDR_W(10), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy0),
    .in_cls(in_cls), .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_last(in_last), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
    .busy(busy0), .done(done0), .err(err0), .err_addr(eaddr0), .wrap(wrap0));

  inst_encode #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy1),
    .in_cls(in_cls), .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_last(in_last), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .busy(busy1), .done(done1), .err(err1), .err_addr(eaddr1), .wrap(wrap1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: derive the word from the instruction-set rules, independent of bit slicing tricks.
  function automatic logic [31:0] model_word(input logic [2:0] cls, input logic [3:0] op,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
      input logic [31:0] imm, output logic bad);
    logic [9:0]  legal;
    logic [31:0] w;
    logic        shift;
    int          v;
    case (cls)
      3'd0: legal = 10'h3FF;
      3'd1: legal = 10'h2FF;
      3'd2: legal = 10'h037;
      3'd3: legal = 10'h007;
      3'd4: legal = 10'h0F3;
      3'd5: legal = 10'h001;
      3'd6: legal = 10'h001;
      default: legal = 10'h003;
    endcase
    bad   = (op > 4'd9) ? 1'b1 : !legal[op];
    shift = (cls == 3'd1) && (op == 4'd1 || op == 4'd5 || op == 4'd9);
    v     = int'(imm);
`ifdef INST_ENCODE_IMM_CHECK_EN
    case (cls)
      3'd1: if (shift) begin if (imm > 32'd31) bad = 1'b1; end
            else if (v < -2048 || v > 2047) bad = 1'b1;
      3'd2, 3'd3, 3'd6: if (v < -2048 || v > 2047) bad = 1'b1;
      3'd4: if (v < -4096 || v > 4095 || (v % 2) != 0) bad = 1'b1;
      3'd5: if (v < -1048576 || v > 1048575 || (v % 2) != 0) bad = 1'b1;
      3'd7: if ((imm % 32'd4096) != 0) bad = 1'b1;
      default: ;
    endcase
`endif
    w = 32'd0;
    w[14:12] = op[2:0];
    w[19:15] = rs1;
    w[24:20] = rs2;
    w[11:7]  = rd;
    case (cls)
      3'd0: begin
        w[6:0] = 7'h33;
        if (op == 4'd8) begin w[31:25] = 7'h20; w[14:12] = 3'd0; end
        if (op == 4'd9) begin w[31:25] = 7'h20; w[14:12] = 3'd5; end
      end
      3'd1: begin
        w[6:0] = 7'h13;
        if (shift) begin
          w[24:20] = imm[4:0];
          w[31:25] = (op == 4'd9) ? 7'h20 : 7'h00;
          if (op == 4'd9) w[14:12] = 3'd5;
        end else w[31:20] = imm[11:0];
      end
      3'd2: begin w[6:0] = 7'h03; w[31:20] = imm[11:0]; end
      3'd3: begin w[6:0] = 7'h23; w[31:25] = imm[11:5]; w[11:7] = imm[4:0]; end
      3'd4: begin
        w[6:0] = 7'h63; w[31] = imm[12]; w[30:25] = imm[10:5];
        w[11:8] = imm[4:1]; w[7] = imm[11];
      end
      3'd5: begin
        w[6:0] = 7'h6F; w[31] = imm[20]; w[30:21] = imm[10:1];
        w[20] = imm[11]; w[19:12] = imm[19:12];
      end
      3'd6: begin w[6:0] = 7'h67; w[14:12] = 3'd0; w[31:20] = imm[11:0]; end
      default: begin
        w[6:0] = (op == 4'd1) ? 7'h17 : 7'h37;
        w[31:12] = imm[31:12];
      end
    endcase
    return bad ? 32'h0000_0013 : w;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] word;
    logic        bad;
    logic        last;
  } ent_t;

  ent_t        q[$];
  ent_t        ent;
  int          cyc = 0;
  int          m_state = 0;
  int          old_state;
  logic        chk_en = 1'b0;
  logic [9:0]  mask[2] = '{10'h3FF, 10'h003};
  logic [9:0]  m_addr[2], e_addr[2], e_eaddr[2];
  logic        e_err[2], e_wrap[2];
  logic        e_we, e_done;
  logic [31:0] e_wdata;
  logic        mbad;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      chk_en = 1'b1;
      m_state = 0;
      q.delete();
      e_we = 1'b0; e_done = 1'b0; e_wdata = '0;
      for (int i = 0; i < 2; i++) begin
        m_addr[i] = '0; e_addr[i] = '0; e_eaddr[i] = '0; e_err[i] = 1'b0; e_wrap[i] = 1'b0;
      end
    end else begin
      old_state = m_state;
      if (old_state == 0 && start) begin
        m_state = 1;
        for (int i = 0; i < 2; i++) begin
          m_addr[i] = '0; e_err[i] = 1'b0; e_wrap[i] = 1'b0; e_eaddr[i] = '0;
        end
      end
      if (old_state == 1 && in_valid) begin
        ent.word = model_word(in_cls, in_op, in_rs1, in_rs2, in_rd, in_imm, mbad);
        ent.bad  = mbad;
        ent.last = in_last;
        ent.due  = cyc + 1;
        q.push_back(ent);
        if (in_last) m_state = 2;
      end
      if (old_state == 2 && e_done) m_state = 0;
      e_we = 1'b0;
      e_done = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ent = q.pop_front();
        e_we = 1'b1; e_done = ent.last; e_wdata = ent.word;
        for (int i = 0; i < 2; i++) begin
          e_addr[i] = m_addr[i];
          if (ent.bad) begin
            if (!e_err[i]) e_eaddr[i] = m_addr[i];
            e_err[i] = 1'b1;
          end
          if (m_addr[i] == mask[i]) e_wrap[i] = 1'b1;
          m_addr[i] = (m_addr[i] + 10'd1) & mask[i];
        end
      end
    end
  end

  logic [9:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [1:0]  log_addr1[$];

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({rdy0, we0, busy0, done0, err0, wrap0, addr0, eaddr0, wdata0} !==
          {m_state == 1, e_we, m_state != 0, e_done, e_err[0], e_wrap[0], e_addr[0], e_eaddr[0], e_wdata}) begin
        errors++;
        $display("FAIL cyc%0d big: rdy/we/busy/done/err/wrap=%b%b%b%b%b%b addr=%h eaddr=%h data=%h expected %b%b%b%b%b%b addr=%h eaddr=%h data=%h",
          cyc, rdy0, we0, busy0, done0, err0, wrap0, addr0, eaddr0, wdata0,
          m_state == 1, e_we, m_state != 0, e_done, e_err[0], e_wrap[0], e_addr[0], e_eaddr[0], e_wdata);
      end
      checks++;
      if ({rdy1, we1, busy1, done1, err1, wrap1, addr1, eaddr1, wdata1} !==
          {m_state == 1, e_we, m_state != 0, e_done, e_err[1], e_wrap[1], e_addr[1][1:0], e_eaddr[1][1:0], e_wdata}) begin
        errors++;
        $display("FAIL cyc%0d small: rdy/we/busy/done/err/wrap=%b%b%b%b%b%b addr=%h eaddr=%h data=%h expected %b%b%b%b%b%b addr=%h eaddr=%h data=%h",
          cyc, rdy1, we1, busy1, done1, err1, wrap1, addr1, eaddr1, wdata1,
          m_state == 1, e_we, m_state != 0, e_done, e_err[1], e_wrap[1], e_addr[1][1:0], e_eaddr[1][1:0], e_wdata);
      end
      if (we0) begin log_addr.push_back(addr0); log_data.push_back(wdata0); end
      if (we1) log_addr1.push_back(addr1);
      $display("cyc %0d we=%b addr=%h data=%h done=%b err=%b wrap_small=%b", cyc, we0, addr0, wdata0, done0, err0, wrap1);
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0; in_last = 1'b0; in_cls = '0; in_op = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
  endtask

  task automatic session_start();
    log_addr.delete(); log_data.delete(); log_addr1.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic beat(input logic [2:0] cls, input logic [3:0] op, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm, input logic last);
    int t;
    for (t = 0; t < 20 && !rdy0; t++) begin @(posedge clk); #1; end
    if (t == 20) check("ready_timeout", 32'(rdy0), 32'd1);
    in_valid = 1'b1; in_cls = cls; in_op = op; in_rs1 = rs1; in_rs2 = rs2;
    in_rd = rd; in_imm = imm; in_last = last;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic wait_done();
    int t;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done0) break;
    end
    if (t == 20) check("done_timeout", 32'(done0), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    // Pin the model with hand-computed words.
    check("model_addi", model_word(3'd1, 4'd0, 5'd0, 5'd0, 5'd1, 32'd5, b), 32'h0050_0093);
    check("model_sub", model_word(3'd0, 4'd8, 5'd1, 5'd2, 5'd3, 32'd0, b), 32'h4020_81B3);
    check("model_beq", model_word(3'd4, 4'd0, 5'd1, 5'd2, 5'd0, -32'sd4, b), 32'hFE20_8EE3);
    check("model_jal", model_word(3'd5, 4'd0, 5'd0, 5'd0, 5'd1, 32'd8, b), 32'h0080_00EF);

    rst_n = 1'b0; start = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", 32'(rdy0), 32'd0);
    check("reset_busy", 32'(busy0), 32'd0);

    // I addi
    session_start();
    beat(3'd1, 4'd0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1);
    wait_done();
    check("a_count", 32'(log_data.size()), 32'd1);
    check("a_addr", 32'(log_addr[0]), 32'd0);
    check("a_data", log_data[0], 32'h0050_0093);

    // back-to-back R/B then two illegal combinations
    session_start();
    beat(3'd0, 4'd8, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    beat(3'd4, 4'd0, 5'd1, 5'd2, 5'd0, -32'sd4, 1'b0);
    beat(3'd2, 4'd3, 5'd1, 5'd0, 5'd4, 32'd0, 1'b0);
    beat(3'd1, 4'd8, 5'd1, 5'd0, 5'd4, 32'd0, 1'b1);
    wait_done();
    check("b_count", 32'(log_data.size()), 32'd4);
    check("b_sub", log_data[0], 32'h4020_81B3);
    check("b_beq", log_data[1], 32'hFE20_8EE3);
    check("b_beq_addr", 32'(log_addr[1]), 32'd1);
    check("b_nop", log_data[2], 32'h0000_0013);
    check("b_nop2", log_data[3], 32'h0000_0013);
    check("b_err", 32'(err0), 32'd1);
    check("b_err_addr", 32'(eaddr0), 32'd2);

    // U / J / SRAI, done with third write
    session_start();
    beat(3'd7, 4'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 1'b0);
    beat(3'd5, 4'd0, 5'd0, 5'd0, 5'd1, 32'd8, 1'b0);
    beat(3'd1, 4'd9, 5'd2, 5'd0, 5'd2, 32'd3, 1'b1);
    wait_done();
    check("c_count", 32'(log_data.size()), 32'd3);
    check("c_lui", log_data[0], 32'h1234_52B7);
    check("c_jal", log_data[1], 32'h0080_00EF);
    check("c_srai", log_data[2], 32'h4031_5113);
    check("c_err_clear", 32'(err0), 32'd0);

    // out-of-range immediate
    session_start();
    beat(3'd1, 4'd0, 5'd0, 5'd0, 5'd1, 32'd4096, 1'b1);
    wait_done();
`ifdef INST_ENCODE_IMM_CHECK_EN
    check("d_data", log_data[0], 32'h0000_0013);
    check("d_err", 32'(err0), 32'd1);
`else
    check("d_data", log_data[0], 32'h0000_0093);
    check("d_err", 32'(err0), 32'd0);
`endif

    // five beats with a gap and an ignored start: small instance wraps
    session_start();
    beat(3'd0, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    beat(3'd0, 4'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    beat(3'd3, 4'd2, 5'd1, 5'd2, 5'd0, 32'd12, 1'b0);
    beat(3'd6, 4'd0, 5'd1, 5'd0, 5'd1, 32'd16, 1'b0);
    beat(3'd2, 4'd4, 5'd1, 5'd0, 5'd7, 32'd1, 1'b1);
    wait_done();
    check("e_count", 32'(log_addr1.size()), 32'd5);
    check("e_addr4", 32'(log_addr1[4]), 32'd0);
    check("e_addr3", 32'(log_addr1[3]), 32'd3);
    check("e_wrap_small", 32'(wrap1), 32'd1);
    check("e_wrap_big", 32'(wrap0), 32'd0);
    check("e_big_addr4", 32'(log_addr[4]), 32'd4);

    // reset mid-stream
    session_start();
    beat(3'd0, 4'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    beat(3'd0, 4'd0, 5'd2, 5'd2, 5'd2, 32'd0, 1'b0);
    beat(3'd0, 4'd0, 5'd3, 5'd3, 5'd3, 32'd0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("f_writes", 32'(log_data.size()), 32'd2);
    check("f_we", 32'(we0), 32'd0);
    check("f_addr", 32'(addr0), 32'd0);
    check("f_data", wdata0, 32'd0);
    check("f_ready", 32'(rdy0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
